// File: rtl/stack_if.sv
// Command/observation bundle for the 16-deep, 4-bit stack register file.
interface stack_if;
    logic [2:0]  cmd;
    logic [3:0]  din;
    logic [63:0] entries;
    logic [3:0]  sel;
    logic [3:0]  top;
    logic [3:0]  next;
    logic [4:0]  depth;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        unf;

    modport master (
        output cmd, din,
        input  entries, sel, top, next, depth, full, empty, ovf, unf
    );
    modport slave (
        input  cmd, din,
        output entries, sel, top, next, depth, full, empty, ovf, unf
    );
endinterface

// File: rtl/stack_register_file.sv
// 16 x 4-bit register stack: one command per clock, sticky overflow/underflow,
// illegal commands leave slots and depth untouched.
module stack_register_file (
    input  logic    clk,
    input  logic    rst_n,
    stack_if.slave  bus
);
    localparam int NS = 16;
    localparam int W  = 4;

    localparam logic [2:0] CMD_NOP     = 3'b000;
    localparam logic [2:0] CMD_PUSH    = 3'b001;
    localparam logic [2:0] CMD_POP     = 3'b010;
    localparam logic [2:0] CMD_REPLACE = 3'b011;
    localparam logic [2:0] CMD_DUP     = 3'b100;
    localparam logic [2:0] CMD_SWAP    = 3'b101;
    localparam logic [2:0] CMD_CLEAR   = 3'b110;
    localparam logic [2:0] CMD_BINOP   = 3'b111;

    logic [NS-1:0][W-1:0] slots, slots_n;
    logic [4:0]           depth, depth_n;
    logic                 ovf, ovf_n, unf, unf_n;

    logic [3:0] ptr, tos, nos;
    logic       is_empty, is_full, two;

    // ptr is only used as a write index when depth<16, so dropping bit 4 is safe
    assign ptr      = depth[3:0];
    assign tos      = ptr - 4'd1;
    assign nos      = ptr - 4'd2;
    assign is_empty = (depth == 5'd0);
    assign is_full  = (depth == 5'd16);
    assign two      = (depth >= 5'd2);

    always_comb begin
        slots_n = slots;
        depth_n = depth;
        ovf_n   = ovf;
        unf_n   = unf;
        case (bus.cmd)
            CMD_PUSH: begin
                if (is_full) ovf_n = 1'b1;
                else begin
                    slots_n[ptr] = bus.din;
                    depth_n      = depth + 5'd1;
                end
            end
            CMD_POP: begin
                if (is_empty) unf_n = 1'b1;
                else          depth_n = depth - 5'd1;
            end
            CMD_REPLACE: begin
                if (is_empty) unf_n = 1'b1;
                else          slots_n[tos] = bus.din;
            end
            CMD_DUP: begin
                if (is_full)       ovf_n = 1'b1;
                else if (is_empty) unf_n = 1'b1;
                else begin
                    slots_n[ptr] = slots[tos];
                    depth_n      = depth + 5'd1;
                end
            end
            CMD_SWAP: begin
                if (!two) unf_n = 1'b1;
                else begin
                    slots_n[tos] = slots[nos];
                    slots_n[nos] = slots[tos];
                end
            end
            CMD_CLEAR: begin
                slots_n = '0;
                depth_n = 5'd0;
                ovf_n   = 1'b0;
                unf_n   = 1'b0;
            end
            CMD_BINOP: begin
                if (!two) unf_n = 1'b1;
                else begin
                    slots_n[nos] = bus.din;
                    depth_n      = depth - 5'd1;
                end
            end
            CMD_NOP: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots <= '0;
            depth <= 5'd0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            slots <= slots_n;
            depth <= depth_n;
            ovf   <= ovf_n;
            unf   <= unf_n;
        end
    end

    assign bus.entries = slots;
    assign bus.sel     = is_empty ? 4'd0 : tos;
    assign bus.top     = is_empty ? 4'd0 : slots[tos];
    assign bus.next    = two ? slots[nos] : 4'd0;
    assign bus.depth   = depth;
    assign bus.full    = is_full;
    assign bus.empty   = is_empty;
    assign bus.ovf     = ovf;
    assign bus.unf     = unf;
endmodule

// File: tb/tb_stack_register_file.sv
// Scoreboard bench: stimulus queues hand-computed expectations, a monitor
// compares them against the DUT after each executed command.
module tb_stack_register_file;
    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, REPL = 3'd3;
    localparam logic [2:0] DUP = 3'd4, SWAP = 3'd5, CLR = 3'd6, BIN = 3'd7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic chk_tgl = 1'b0;
    stack_if bus ();

    stack_register_file dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  depth;
        logic [3:0]  top;
        logic [3:0]  next;
        logic        ovf;
        logic        unf;
        logic        chk_ent;
        logic [63:0] ent;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic exp_t mk(input string nm, input logic [4:0] d, input logic [3:0] t,
                                input logic [3:0] n, input logic o, input logic u,
                                input logic ce, input logic [63:0] e);
        exp_t x;
        x.name = nm; x.depth = d; x.top = t; x.next = n;
        x.ovf = o; x.unf = u; x.chk_ent = ce; x.ent = e;
        return x;
    endfunction

    // Monitor: drains expectations 2ns after each edge or on an explicit async poke.
    always begin
        @(chk_tgl or posedge clk);
        #2;
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [3:0] esel;
            logic       ok;
            e    = exp_q.pop_front();
            esel = (e.depth == 5'd0) ? 4'd0 : 4'(e.depth - 5'd1);
            ok = (bus.depth == e.depth) && (bus.top == e.top) && (bus.next == e.next) &&
                 (bus.sel == esel) && (bus.ovf == e.ovf) && (bus.unf == e.unf) &&
                 (bus.full == (e.depth == 5'd16)) && (bus.empty == (e.depth == 5'd0)) &&
                 (!e.chk_ent || bus.entries == e.ent);
            n_vec++;
            if (!ok) begin
                n_bad++;
                $display("FAIL %s: got depth=%0d sel=%h top=%h next=%h full=%b empty=%b ovf=%b unf=%b entries=%h ; want depth=%0d sel=%h top=%h next=%h ovf=%b unf=%b entries=%h(chk=%b)",
                         e.name, bus.depth, bus.sel, bus.top, bus.next, bus.full, bus.empty,
                         bus.ovf, bus.unf, bus.entries, e.depth, esel, e.top, e.next,
                         e.ovf, e.unf, e.ent, e.chk_ent);
            end
        end
    end

    task automatic step(input logic [2:0] c, input logic [3:0] d, input string nm,
                        input logic [4:0] ed, input logic [3:0] et, input logic [3:0] en,
                        input logic eo, input logic eu,
                        input logic ce = 1'b0, input logic [63:0] ee = '0);
        @(negedge clk);
        bus.cmd = c;
        bus.din = d;
        @(posedge clk);
        exp_q.push_back(mk(nm, ed, et, en, eo, eu, ce, ee));
        @(negedge clk);
        bus.cmd = NOP;
    endtask

    initial begin
        bus.cmd = NOP;
        bus.din = 4'd0;
        #1;
        exp_q.push_back(mk("reset", 5'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 64'd0));
        chk_tgl = ~chk_tgl;
        #20 rst_n = 1'b1;

        // basic push / swap / binop / pop sequence
        step(PUSH, 4'h3, "push3", 5'd1, 4'h3, 4'h0, 0, 0);
        step(PUSH, 4'h7, "push7", 5'd2, 4'h7, 4'h3, 0, 0);
        step(PUSH, 4'h9, "push9", 5'd3, 4'h9, 4'h7, 0, 0, 1, 64'h973);
        step(SWAP, 4'h0, "swap", 5'd3, 4'h7, 4'h9, 0, 0, 1, 64'h793);
        step(BIN, 4'h5, "binop5", 5'd2, 4'h5, 4'h3, 0, 0, 1, 64'h753);
        step(POP, 4'h0, "pop1", 5'd1, 4'h3, 4'h0, 0, 0, 1, 64'h753);
        step(POP, 4'h0, "pop2", 5'd0, 4'h0, 4'h0, 0, 0, 1, 64'h753);
        step(POP, 4'h0, "pop_empty", 5'd0, 4'h0, 4'h0, 0, 1, 1, 64'h753);
        step(NOP, 4'h0, "nop_sticky", 5'd0, 4'h0, 4'h0, 0, 1, 1, 64'h753);
        step(CLR, 4'h0, "clear1", 5'd0, 4'h0, 4'h0, 0, 0, 1, 64'd0);

        // fill to 16, then overflow with the 17th
        for (int k = 0; k < 16; k++)
            step(PUSH, 4'(k), $sformatf("fill%0d", k), 5'(k + 1), 4'(k),
                 (k == 0) ? 4'd0 : 4'(k - 1), 0, 0);
        step(PUSH, 4'h0, "push17_ovf", 5'd16, 4'hF, 4'hE, 1, 0, 1, 64'hFEDCBA9876543210);
        step(DUP, 4'h0, "dup_full", 5'd16, 4'hF, 4'hE, 1, 0, 1, 64'hFEDCBA9876543210);
        step(POP, 4'h0, "pop_keep_ovf", 5'd15, 4'hE, 4'hD, 1, 0, 1, 64'hFEDCBA9876543210);
        step(DUP, 4'h0, "dup_15", 5'd16, 4'hE, 4'hE, 1, 0, 1, 64'hEEDCBA9876543210);
        step(CLR, 4'h0, "clear2", 5'd0, 4'h0, 4'h0, 0, 0, 1, 64'd0);

        // depth-1 underflow cases
        step(PUSH, 4'h6, "push6", 5'd1, 4'h6, 4'h0, 0, 0);
        step(SWAP, 4'h0, "swap_d1", 5'd1, 4'h6, 4'h0, 0, 1, 1, 64'h6);
        step(BIN, 4'h2, "binop_d1", 5'd1, 4'h6, 4'h0, 0, 1, 1, 64'h6);
        step(REPL, 4'hA, "replaceA", 5'd1, 4'hA, 4'h0, 0, 1, 1, 64'hA);
        step(DUP, 4'h0, "dup_d1", 5'd2, 4'hA, 4'hA, 0, 1, 1, 64'hAA);
        step(CLR, 4'h0, "clear3", 5'd0, 4'h0, 4'h0, 0, 0, 1, 64'd0);
        step(REPL, 4'h5, "replace_empty", 5'd0, 4'h0, 4'h0, 0, 1, 1, 64'd0);
        step(CLR, 4'h0, "clear4", 5'd0, 4'h0, 4'h0, 0, 0, 1, 64'd0);
        step(DUP, 4'h0, "dup_empty", 5'd0, 4'h0, 4'h0, 0, 1, 1, 64'd0);
        step(CLR, 4'h0, "clear5", 5'd0, 4'h0, 4'h0, 0, 0, 1, 64'd0);

        // async reset between edges at depth 5
        for (int k = 1; k <= 5; k++)
            step(PUSH, 4'(k), $sformatf("pre_rst%0d", k), 5'(k), 4'(k), 4'(k - 1), 0, 0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        exp_q.push_back(mk("async_reset", 5'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 64'd0));
        chk_tgl = ~chk_tgl;
        #2 rst_n = 1'b1;
        step(PUSH, 4'h4, "push_after_rst", 5'd1, 4'h4, 4'h0, 0, 0, 1, 64'h4);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/stack_register_file.md
STACK_REGISTER_FILE -- requirements
Module: stack_register_file

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port cmd  input  3  stack command, sampled every rising edge.
REQ-004 SHALL have port din  input  4  data word for PUSH, REPLACE and BINOP.
REQ-005 SHALL have port entries  output  64  16 stack slots, flattened; slot k at bits [4k+3:4k]; feeds the 16:1 input selector data inputs.
REQ-006 SHALL have port sel  output  4  index of the top-of-stack slot (depth-1), or 0 when empty; drives the selector's select input.
REQ-007 SHALL have port top  output  4  contents of slot depth-1, or 0 when empty.
REQ-008 SHALL have port next  output  4  contents of slot depth-2, or 0 when depth<2.
REQ-009 SHALL have port depth  output  5  number of valid entries, 0..16.
REQ-010 SHALL have ports full and empty  output  1 each  depth==16 and depth==0 respectively.
REQ-011 SHALL have ports ovf and unf  output  1 each  sticky overflow and underflow error flags.

Function
REQ-012 SHALL decode cmd as: 000 NOP, 001 PUSH, 010 POP, 011 REPLACE, 100 DUP, 101 SWAP, 110 CLEAR, 111 BINOP.
REQ-013 SHALL execute exactly one command per clock; results visible on all outputs after that rising edge (latency 1); no stall or handshake.
REQ-014 SHALL hold slots, depth, ovf and unf in registers; sel, top, next, full and empty combinational from them.
REQ-015 PUSH: slot[depth]<=din, depth+1.
REQ-016 POP: depth-1; vacated slot keeps its old value; entries is not cleared.
REQ-017 REPLACE: slot[depth-1]<=din; depth unchanged.
REQ-018 DUP: slot[depth]<=slot[depth-1], depth+1.
REQ-019 SWAP: exchange slot[depth-1] and slot[depth-2]; depth unchanged.
REQ-020 BINOP: slot[depth-2]<=din, depth-1 (pop two, push ALU result).
REQ-021 CLEAR: depth<=0; all 16 slots<=0; ovf<=0; unf<=0.
REQ-022 PUSH or DUP when full: no state change except ovf<=1.
REQ-023 POP or REPLACE when empty, or DUP when empty: no state change except unf<=1.
REQ-024 SWAP or BINOP when depth<2: no state change except unf<=1.
REQ-025 ovf and unf SHALL remain set until CLEAR or reset; a legal command never clears them.
REQ-026 Depth arithmetic SHALL never wrap: depth stays within 0..16 under all command sequences.
REQ-027 NOP and any error-suppressed command SHALL leave slots and depth bit-identical.

Reset
REQ-028 rst_n low SHALL immediately (no clock needed) force depth=0, all slots=0, ovf=0, unf=0; thus sel=0, top=0, next=0, empty=1, full=0, entries=0.
REQ-029 Reset asserted mid-sequence SHALL abort pending state; first command after rst_n rises is taken on the next rising edge.

Verification
REQ-030 Reset then PUSH 3, PUSH 7, PUSH 9 -> depth=3, sel=2, top=9, next=7, entries[11:0]=0x973.
REQ-031 From [3,7,9]: SWAP -> top=7, next=9; BINOP din=5 -> depth=2, top=5, next=3; POP, POP, POP -> depth=0, empty=1, unf=1.
REQ-032 17 PUSH of din=k[3:0] for k=0..16 -> depth=16, full=1, sel=15, top=0xF, ovf=1 after 17th, slots unchanged by it.
REQ-033 Full stack: DUP -> no change, ovf=1; CLEAR -> depth=0, entries=0, ovf=0, unf=0.
REQ-034 depth=1: SWAP and BINOP each -> depth=1, top unchanged, unf=1; REPLACE din=0xA -> top=0xA.
REQ-035 rst_n pulsed low between clock edges with depth=5 -> outputs read reset values before next edge; following PUSH 4 -> depth=1, top=4.
